button_event_classifier: RTL and testbench

- Consumes the single-bit debounced level (`clean_out`) from the debouncer stage.
- Classifies each press into exactly one of three one-cycle event pulses: single click, double click or long press.
- Also provides a level flag while a long press is being held.
- Sits between the debouncer and the UI/control logic, so downstream logic never has to time button presses itself.

---
 rtl/button_event_classifier.sv | 138 +++++++++++++
 tb/tb_button_event_classifier.sv | 128 ++++++++++++
 2 files changed

// File: rtl/button_event_classifier.sv
// Turns a debounced button level into single-click, double-click and long-press pulses.
// Define BTN_EVENT_COUNT_EN to add an 8-bit running count of emitted events.
module button_event_classifier #(
  parameter int CNT_WIDTH   = 16,
  parameter int LONG_CYCLES = 50000,
  parameter int GAP_CYCLES  = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic       long_held
`ifdef BTN_EVENT_COUNT_EN
  ,
  output logic [7:0] event_count
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESSED   = 3'd1;
  localparam logic [2:0] LONG_HELD = 3'd2;
  localparam logic [2:0] WAIT_GAP  = 3'd3;
  localparam logic [2:0] WAIT_REL  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);

  generate
    if (LONG_CYCLES < 2 || GAP_CYCLES < 2 ||
        LONG_CYCLES > (1 << CNT_WIDTH) || GAP_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_cfg
      $error("button_event_classifier: LONG_CYCLES/GAP_CYCLES out of range for CNT_WIDTH");
    end
  endgenerate

  logic [2:0]           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 btn_q;
  logic                 rise;
  logic                 single_nxt, double_nxt, long_nxt, held_nxt;

  assign rise = btn_in & ~btn_q;

  // Next-state logic; the counter restarts from zero on every state change.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    held_nxt   = long_held;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end
      end
      PRESSED: begin
        if (!btn_in) begin
          state_nxt = WAIT_GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          held_nxt  = 1'b1;
          state_nxt = LONG_HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn_in) begin
          held_nxt  = 1'b0;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      WAIT_GAP: begin
        if (btn_in) begin
          double_nxt = 1'b1;
          state_nxt  = WAIT_REL;
          cnt_nxt    = '0;
        end else if (cnt == GAP_LAST) begin
          single_nxt = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!btn_in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        held_nxt  = 1'b0;
      end
    endcase
  end

  // Clearing btn_q on reset makes a button held across reset release count as a fresh rise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      btn_q        <= 1'b0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      long_held    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      btn_q        <= btn_in;
      single_click <= single_nxt;
      double_click <= double_nxt;
      long_press   <= long_nxt;
      long_held    <= held_nxt;
    end
  end

`ifdef BTN_EVENT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      event_count <= 8'd0;
    end else if (single_nxt || double_nxt || long_nxt) begin
      event_count <= event_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier (LONG_CYCLES=8, GAP_CYCLES=6).
// Outputs are packed as {single_click, double_click, long_press, long_held}.
module tb_button_event_classifier;

  logic clk;
  logic rst;
  logic btn_in;
  logic single_click, double_click, long_press, long_held;
`ifdef BTN_EVENT_COUNT_EN
  logic [7:0] event_count;
  logic [7:0] expEvents;
`endif

  int checkCount;
  int passCount;

  button_event_classifier #(
    .CNT_WIDTH  (4),
    .LONG_CYCLES(8),
    .GAP_CYCLES (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .long_held   (long_held)
`ifdef BTN_EVENT_COUNT_EN
    ,
    .event_count (event_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Drive one input sample, clock it in, then check outputs 1 ns after the edge.
  task automatic applyStimulus(input logic b, input logic [3:0] exp, input string tag);
    btn_in = b;
    @(posedge clk);
    #1;
    checkOutput(tag, {4'd0, single_click, double_click, long_press, long_held}, {4'd0, exp});
`ifdef BTN_EVENT_COUNT_EN
    if (!rst) expEvents = 8'd0;
    else if (|exp[3:1]) expEvents = expEvents + 8'd1;
    checkOutput({tag, "_count"}, event_count, expEvents);
`endif
  endtask

  task automatic runSeq(input int n, input logic b, input logic [3:0] exp, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(b, exp, tag);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
`ifdef BTN_EVENT_COUNT_EN
    expEvents  = 8'd0;
`endif
    rst    = 1'b0;
    btn_in = 1'b0;

    // Reset held while the button toggles; nothing may fire.
    applyStimulus(1'b1, 4'b0000, "rst_hold0");
    applyStimulus(1'b0, 4'b0000, "rst_hold1");
    applyStimulus(1'b1, 4'b0000, "rst_hold2");
    rst = 1'b1;
    runSeq(4, 1'b0, 4'b0000, "idle");

    // Short press: release sampled on tick 4, single_click six ticks later.
    runSeq(3, 1'b1, 4'b0000, "short_hi");
    runSeq(6, 1'b0, 4'b0000, "short_gap");
    applyStimulus(1'b0, 4'b1000, "short_single");
    runSeq(3, 1'b0, 4'b0000, "short_after");

    // Double click: second rise sampled inside the gap.
    runSeq(3, 1'b1, 4'b0000, "dbl_hi1");
    runSeq(2, 1'b0, 4'b0000, "dbl_lo");
    applyStimulus(1'b1, 4'b0100, "dbl_pulse");
    runSeq(2, 1'b1, 4'b0000, "dbl_hi2");
    runSeq(10, 1'b0, 4'b0000, "dbl_after");

    // Long press: pulse on the ninth tick, long_held until the fall is sampled.
    runSeq(8, 1'b1, 4'b0000, "long_count");
    applyStimulus(1'b1, 4'b0011, "long_pulse");
    runSeq(11, 1'b1, 4'b0001, "long_held");
    applyStimulus(1'b0, 4'b0000, "long_release");
    runSeq(10, 1'b0, 4'b0000, "long_after");

    // Gap boundary: gap expires first, so the next high is a fresh press.
    runSeq(3, 1'b1, 4'b0000, "gapA_hi");
    runSeq(6, 1'b0, 4'b0000, "gapA_lo");
    applyStimulus(1'b0, 4'b1000, "gapA_single");
    runSeq(3, 1'b1, 4'b0000, "gapA_fresh");
    runSeq(6, 1'b0, 4'b0000, "gapA_lo2");
    applyStimulus(1'b0, 4'b1000, "gapA_single2");
    runSeq(2, 1'b0, 4'b0000, "gapA_after");

    // Gap boundary: high on the last waiting tick still counts as a double click.
    runSeq(3, 1'b1, 4'b0000, "gapB_hi");
    runSeq(6, 1'b0, 4'b0000, "gapB_lo");
    applyStimulus(1'b1, 4'b0100, "gapB_double");
    applyStimulus(1'b1, 4'b0000, "gapB_hold");
    runSeq(4, 1'b0, 4'b0000, "gapB_after");

    // Reset mid-press discards timing; a still-held button then restarts as a new press.
    runSeq(5, 1'b1, 4'b0000, "rstmid_hi");
    rst = 1'b0;
    runSeq(2, 1'b1, 4'b0000, "rstmid_rst");
    rst = 1'b1;
    runSeq(8, 1'b1, 4'b0000, "rstmid_count");
    applyStimulus(1'b1, 4'b0011, "rstmid_long");
    runSeq(2, 1'b1, 4'b0001, "rstmid_held");
    applyStimulus(1'b0, 4'b0000, "rstmid_release");
    runSeq(3, 1'b0, 4'b0000, "rstmid_after");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
